// File: rtl/word_ram.sv
// word_ram - inferred simple dual-port RAM with registered read and synchronous reset
module word_ram #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clock50,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_address,
  input  logic [DATA_BITS-1:0] write_data,
  input  logic [ADDR_BITS-1:0] read_address,
  output logic [DATA_BITS-1:0] read_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Write port: storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clock50) begin
    if (write_enable) begin
      mem[write_address] <= write_data;
    end
  end

  // Read port: one-cycle latency; reset only clears the output register.
  always_ff @(posedge clock50) begin
    if (reset) begin
      read_data <= '0;
    end else begin
      read_data <= mem[read_address];
    end
  end

endmodule

// File: rtl/parallel_bus_ram_slave.sv
// parallel_bus_ram_slave - 8-bit async parallel bus slave giving word access to an internal RAM
module parallel_bus_ram_slave #(
  parameter int WIDTH = 8,
  parameter int TRANSACTIONS_PER_WORD = 2,
  parameter int LOG2_OF_TRANSACTIONS_PER_WORD = $clog2(TRANSACTIONS_PER_WORD)
) (
  input  logic             clock50,
  input  logic             reset,
  input  logic             clock10,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             read,
  input  logic             register_select,
  input  logic             enable,
  output logic             ack_valid,
  output logic             lemo,
  output logic             other0,
  output logic             other1,
  output logic [7:0]       leds
);

  localparam int WORD_BITS = WIDTH * TRANSACTIONS_PER_WORD;
  localparam int IDX_BITS  = LOG2_OF_TRANSACTIONS_PER_WORD;
  localparam logic [IDX_BITS-1:0] WORD_MAX = IDX_BITS'(TRANSACTIONS_PER_WORD - 1);

  logic [3:0]           stretch;
  logic                 reset50;
  logic [2:0]           ack_pipe;
  logic [WIDTH-1:0]     address;
  logic [WIDTH-1:0]     pre_bus;
  logic [WIDTH-1:0]     write_data [TRANSACTIONS_PER_WORD];
  logic [1:0]           wstate;
  logic [1:0]           rstate;
  logic                 astate;
  logic [IDX_BITS-1:0]  wword;
  logic [IDX_BITS-1:0]  rword;
  logic                 write_strobe;
  logic                 checksum_flag;
  logic [31:0]          errors;
  logic [WORD_BITS-1:0] write_word;
  logic [WORD_BITS-1:0] read_word;

  // Stretch the external reset so all bus logic stays quiet for 9 cycles after release.
  always_ff @(posedge clock50) begin
    if (reset) begin
      stretch <= '0;
      reset50 <= 1'b1;
    end else begin
      if (!stretch[3]) begin
        stretch <= stretch + 4'd1;
      end
      reset50 <= ~stretch[3];
    end
  end

  // Acknowledge is the strobe delayed by three flops so the master can pace itself.
  always_ff @(posedge clock50) begin
    if (reset) begin
      ack_pipe <= '0;
    end else begin
      ack_pipe <= {ack_pipe[1:0], enable};
    end
  end

  // Assemble the RAM word; byte index TRANSACTIONS_PER_WORD-1 is the most significant.
  always_comb begin
    write_word = '0;
    for (int i = 0; i < TRANSACTIONS_PER_WORD; i++) begin
      write_word[i*WIDTH +: WIDTH] = write_data[i];
    end
  end

  // Bus protocol: sample once per strobe, advance byte counters while the strobe is low.
  always_ff @(posedge clock50) begin
    if (reset50) begin
      address       <= '0;
      pre_bus       <= '0;
      for (int i = 0; i < TRANSACTIONS_PER_WORD; i++) begin
        write_data[i] <= '0;
      end
      wstate        <= '0;
      rstate        <= '0;
      astate        <= 1'b0;
      wword         <= WORD_MAX;
      rword         <= WORD_MAX;
      write_strobe  <= 1'b0;
      checksum_flag <= 1'b0;
      errors        <= '0;
    end else begin
      write_strobe <= 1'b0;
      if (enable) begin
        if (!read && !register_select) begin
          if (!astate) begin
            address <= bus;
            astate  <= 1'b1;
          end
        end else if (!read) begin
          if (wstate == 2'b00) begin
            write_data[wword] <= bus;
            wstate[0]         <= 1'b1;
          end
        end else begin
          if (rstate == 2'b00) begin
            pre_bus   <= read_word[int'(rword)*WIDTH +: WIDTH];
            rstate[0] <= 1'b1;
          end
        end
      end else begin
        if (wstate[0]) begin
          wstate[0] <= 1'b0;
          if (wword != '0) begin
            wword <= wword - IDX_BITS'(1);
          end else begin
            wstate[1]    <= 1'b1;
            write_strobe <= 1'b1;
          end
        end
        if (wstate[1]) begin
          wstate        <= 2'b00;
          wword         <= WORD_MAX;
          checksum_flag <= (write_word[15:0] == 16'h1507);
        end
        if (rstate[0]) begin
          rstate[0] <= 1'b0;
          if (rword != '0) begin
            rword <= rword - IDX_BITS'(1);
          end else begin
            rstate[1] <= 1'b1;
          end
        end
        if (rstate[1]) begin
          rstate <= 2'b00;
          rword  <= WORD_MAX;
        end
        // A new address abandons any half-transferred word and counts it as an error.
        if (astate) begin
          astate <= 1'b0;
          if (wword != WORD_MAX || rword != WORD_MAX) begin
            errors <= errors + 32'd1;
          end
          wstate <= 2'b00;
          rstate <= 2'b00;
          wword  <= WORD_MAX;
          rword  <= WORD_MAX;
        end
      end
    end
  end

  word_ram #(
    .ADDR_BITS (WIDTH),
    .DATA_BITS (WORD_BITS)
  ) u_word_ram (
    .clock50       (clock50),
    .reset         (reset50),
    .write_enable  (write_strobe),
    .write_address (address),
    .write_data    (write_word),
    .read_address  (address),
    .read_data     (read_word)
  );

  assign bus       = read ? pre_bus : {WIDTH{1'bz}};
  assign ack_valid = ack_pipe[2];
  assign lemo      = 1'b0;
  assign other0    = 1'b0;
  assign other1    = 1'b0;
  assign leds      = write_data[0][7:0];

endmodule

// File: tb/tb_parallel_bus_ram_slave.sv
// tb/tb_parallel_bus_ram_slave.sv - scoreboard bench for the parallel bus RAM slave
module tb_parallel_bus_ram_slave;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock50 = 1'b0;
  logic        clock10 = 1'b0;
  logic        reset;
  logic        read;
  logic        register_select;
  logic        enable;
  logic        ack_valid;
  logic        lemo;
  logic        other0;
  logic        other1;
  logic [7:0]  leds;
  wire  [7:0]  bus;
  logic [7:0]  bus_drive;
  logic        tb_drive;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         wq[$];
  logic [7:0]  rq[$];
  logic        ack_prev = 1'b0;
  wr_t         wexp;
  logic [7:0]  rexp;

  assign bus = tb_drive ? bus_drive : 8'bz;

  always #10 clock50 = ~clock50;
  always #50 clock10 = ~clock10;

  parallel_bus_ram_slave #(
    .WIDTH                 (8),
    .TRANSACTIONS_PER_WORD (4)
  ) dut (
    .clock50         (clock50),
    .reset           (reset),
    .clock10         (clock10),
    .bus             (bus),
    .read            (read),
    .register_select (register_select),
    .enable          (enable),
    .ack_valid       (ack_valid),
    .lemo            (lemo),
    .other0          (other0),
    .other1          (other1),
    .leds            (leds)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: RAM writes and read bytes are popped from the scoreboard as the DUT presents them.
  always @(negedge clock50) begin
    if (dut.write_strobe === 1'b1) begin
      if (wq.size() == 0) begin
        check("unexpected_write_strobe", 32'd1, 32'd0);
      end else begin
        wexp = wq.pop_front();
        check("write_address", {24'd0, dut.address}, {24'd0, wexp.addr});
        check("write_word", dut.write_word, wexp.data);
      end
    end
    if (ack_valid && !ack_prev && read) begin
      if (rq.size() == 0) begin
        check("unexpected_read_byte", 32'd1, 32'd0);
      end else begin
        rexp = rq.pop_front();
        check("read_byte", {24'd0, bus}, {24'd0, rexp});
      end
    end
    ack_prev = ack_valid;
  end

  // One strobe: hold enable until ack (exactly 3 clocks), then drop it and wait for ack to clear.
  task automatic pulse(input logic rs, input logic rd, input logic [7:0] d);
    @(negedge clock50);
    register_select = rs;
    read            = rd;
    tb_drive        = !rd;
    bus_drive       = d;
    enable          = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock50);
      check("ack_rise", {31'd0, ack_valid}, (i == 3) ? 32'd1 : 32'd0);
    end
    enable = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock50);
      check("ack_fall", {31'd0, ack_valid}, (i == 3) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] w);
    wr_t e;
    e.addr = a;
    e.data = w;
    wq.push_back(e);
    pulse(1'b0, 1'b0, a);
    for (int i = 3; i >= 0; i--) pulse(1'b1, 1'b0, w[i*8 +: 8]);
    check("leds", {24'd0, leds}, {24'd0, w[7:0]});
  endtask

  task automatic read_word(input logic [7:0] a, input logic [31:0] w);
    pulse(1'b0, 1'b0, a);
    for (int i = 3; i >= 0; i--) begin
      rq.push_back(w[i*8 +: 8]);
      pulse(1'b1, 1'b1, 8'h00);
    end
  endtask

  task automatic do_reset();
    int n;
    @(negedge clock50);
    reset = 1'b1;
    repeat (2) @(negedge clock50);
    reset = 1'b0;
    n = 0;
    while (dut.reset50 && n < 20) begin
      @(negedge clock50);
      n++;
      check("ack_in_stretch", {31'd0, ack_valid}, 32'd0);
    end
    check("reset50_cycles", n, 32'd9);
  endtask

  initial begin
    reset           = 1'b1;
    read            = 1'b0;
    register_select = 1'b0;
    enable          = 1'b0;
    tb_drive        = 1'b1;
    bus_drive       = 8'h00;

    do_reset();
    check("reset_leds", {24'd0, leds}, 32'd0);
    check("reset_errors", dut.errors, 32'd0);
    check("tied_outputs", {29'd0, lemo, other0, other1}, 32'd0);

    write_word(8'h4c, 32'h31232a12);
    check("checksum_clear", {31'd0, dut.checksum_flag}, 32'd0);
    read_word(8'h4c, 32'h31232a12);

    @(negedge clock50);
    read      = 1'b0;
    tb_drive  = 1'b1;
    bus_drive = 8'h5a;
    #1;
    check("bus_released", {24'd0, bus}, 32'h5a);

    write_word(8'h4d, 32'h0badc034);
    write_word(8'h4e, 32'h11223356);
    write_word(8'h4f, 32'hcafe0078);
    read_word(8'h4c, 32'h31232a12);
    read_word(8'h4d, 32'h0badc034);
    read_word(8'h4e, 32'h11223356);
    read_word(8'h4f, 32'hcafe0078);
    check("errors_clean", dut.errors, 32'd0);

    pulse(1'b0, 1'b0, 8'h50);
    pulse(1'b1, 1'b0, 8'haa);
    pulse(1'b1, 1'b0, 8'hbb);
    pulse(1'b0, 1'b0, 8'h51);
    check("errors_partial", dut.errors, 32'd1);
    write_word(8'h51, 32'hdeadbeef);
    read_word(8'h51, 32'hdeadbeef);
    check("errors_after_recovery", dut.errors, 32'd1);

    write_word(8'h52, 32'h00001507);
    check("checksum_set", {31'd0, dut.checksum_flag}, 32'd1);

    pulse(1'b0, 1'b0, 8'h60);
    pulse(1'b1, 1'b0, 8'h11);
    do_reset();
    repeat (4) @(negedge clock50);
    check("reset_mid_errors", dut.errors, 32'd0);
    check("reset_mid_wword", {30'd0, dut.wword}, 32'd3);
    check("reset_mid_leds", {24'd0, leds}, 32'd0);
    read_word(8'h4e, 32'h11223356);

    repeat (4) @(negedge clock50);
    check("write_queue_empty", wq.size(), 32'd0);
    check("read_queue_empty", rq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
